// File: rtl/pseudorandom_multi_if.sv
// rtl/pseudorandom_multi_if.sv - Wishbone classic slave bus bundle for pseudorandom_multi
interface pseudorandom_multi_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/pseudorandom_multi.sv
// rtl/pseudorandom_multi.sv - multi-channel Galois LFSR bank with a Wishbone register file
module pseudorandom_multi #(
    parameter int          NB_CHAN      = 4,
    parameter int          WIDTH        = 32,
    parameter logic [31:0] DEFAULT_TAPS = 32'h80200003,
    parameter logic [31:0] DEFAULT_SEED = 32'h00000001
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    pseudorandom_multi_if.slave      wbs,
    output logic [NB_CHAN*WIDTH-1:0] rnd_o,
    output logic [NB_CHAN-1:0]       rnd_upd_o
);
    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_FREE = 2'd1,
        MODE_READ = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam logic [WIDTH-1:0] L_TAPS = DEFAULT_TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_SEED = DEFAULT_SEED[WIDTH-1:0];

    logic        r_ack;
    logic [31:0] r_dat;

    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_chan;
    logic [1:0]  w_reg;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    logic [1:0]       w_mode  [NB_CHAN];
    logic [WIDTH-1:0] w_taps  [NB_CHAN];
    logic [WIDTH-1:0] w_state [NB_CHAN];

    // A request is only taken while ack is low, so acks can never be back-to-back.
    assign w_req  = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~r_ack;
    assign w_wr   = w_req & wbs.wbs_we_i & (wbs.wbs_sel_i == 4'hF);
    assign w_rd   = w_req & ~wbs.wbs_we_i;
    assign w_chan = wbs.wbs_adr_i[6:4];
    assign w_reg  = wbs.wbs_adr_i[3:2];

    assign w_unused_bits = ^{wbs.wbs_adr_i[31:7], wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < NB_CHAN; c++) begin
            if (w_chan == 3'(c)) begin
                case (w_reg)
                    2'd0:    w_rdata = {30'd0, w_mode[c]};
                    2'd1:    w_rdata = 32'(w_taps[c]);
                    2'd3:    w_rdata = 32'(w_state[c]);
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else if (w_req) begin
            r_ack <= 1'b1;
            r_dat <= wbs.wbs_we_i ? 32'd0 : w_rdata;
        end else begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

    for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
        mode_t            r_mode;
        logic [WIDTH-1:0] r_taps;
        logic [WIDTH-1:0] r_state;
        logic             r_upd;

        logic             w_hit;
        logic             w_ctrl_wr;
        logic             w_taps_wr;
        logic             w_seed_wr;
        logic             w_step;
        logic [WIDTH-1:0] w_seed;
        logic [WIDTH-1:0] w_next;

        assign w_hit     = (w_chan == 3'(c));
        assign w_ctrl_wr = w_wr & w_hit & (w_reg == 2'd0);
        assign w_taps_wr = w_wr & w_hit & (w_reg == 2'd1);
        assign w_seed_wr = w_wr & w_hit & (w_reg == 2'd2);
        // READ mode steps on the same edge that latches the pre-step value into r_dat.
        assign w_step    = (r_mode == MODE_FREE) |
                           ((r_mode == MODE_READ) & w_rd & w_hit & (w_reg == 2'd3));
        assign w_seed    = wbs.wbs_dat_i[WIDTH-1:0];
        assign w_next    = (r_state >> 1) ^ (r_state[0] ? r_taps : '0);

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                r_mode  <= MODE_STOP;
                r_taps  <= L_TAPS;
                r_state <= L_SEED;
                r_upd   <= 1'b0;
            end else begin
                if (w_ctrl_wr) begin
                    r_mode <= mode_t'(wbs.wbs_dat_i[1:0]);
                end
                if (w_taps_wr) begin
                    r_taps <= w_seed;
                end
                if (w_seed_wr) begin
                    r_state <= (w_seed == '0) ? WIDTH'(1) : w_seed;
                end else if (w_step) begin
                    r_state <= w_next;
                end
                r_upd <= w_seed_wr | w_step;
            end
        end

        assign w_mode[c]                 = r_mode;
        assign w_taps[c]                 = r_taps;
        assign w_state[c]                = r_state;
        assign rnd_o[c*WIDTH +: WIDTH]   = r_state;
        assign rnd_upd_o[c]              = r_upd;
    end
endmodule
